// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bus: pipeline register addresses and controls in, stall/flush/forward controls out.
// master = core datapath/controller side, slave = hazard unit.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MulStartE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MulBusy, MulDoneE;
  logic [CNT_W-1:0]  StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
           MulBusy, MulDoneE, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MulStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
           MulBusy, MulDoneE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit with multi-cycle execute FSM and 3-way forwarding.
// Optional stall/flush performance counters enabled by defining HAZARD_PERF_EN.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_mc_if.slave hz
);
  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LAT > 2) ? (MUL_LAT - 2) : 0);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        stateReg, stateNext;
  logic [CW-1:0] cntReg, cntNext;
  logic          lwStall, busy, stallF;

  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && hz.RdM != REG_ZERO && hz.RdM == hz.Rs1E)
      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != REG_ZERO && hz.RdW == hz.Rs1E)
      hz.ForwardAE = 2'b01;
  end

  always_comb begin
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RdM != REG_ZERO && hz.RdM == hz.Rs2E)
      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != REG_ZERO && hz.RdW == hz.Rs2E)
      hz.ForwardBE = 2'b01;
  end

  assign lwStall = (hz.ResultSrcE == 2'b01) && (hz.RdE != REG_ZERO) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Leaving BUSY at cnt<=1 gives MUL_LAT-2 busy cycles, with a floor of one.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (hz.MulStartE && !hz.PCSrcE && (MUL_LAT > 1)) begin
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      BUSY: begin
        cntNext = cntReg - CW'(1);
        if (cntReg <= CW'(1)) begin
          stateNext = DONE;
          cntNext   = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy        = (stateReg == BUSY);
  assign stallF      = lwStall | busy;
  assign hz.StallF   = stallF;
  assign hz.StallD   = stallF;
  assign hz.StallE   = busy;
  assign hz.FlushD   = hz.PCSrcE;
  // The op held in E must never be bubbled, so busy masks the E flush.
  assign hz.FlushE   = (lwStall | hz.PCSrcE) & ~busy;
  assign hz.FlushM   = busy;
  assign hz.MulBusy  = busy;
  assign hz.MulDoneE = (stateReg == DONE);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCntReg, flushCntReg;
  logic             flushAny;

  assign flushAny = hz.PCSrcE | ((lwStall | hz.PCSrcE) & ~busy) | busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (stallF && stallCntReg != {CNT_W{1'b1}})
        stallCntReg <= stallCntReg + CNT_W'(1);
      if (flushAny && flushCntReg != {CNT_W{1'b1}})
        flushCntReg <= flushCntReg + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stallCntReg;
  assign hz.FlushCnt = flushCntReg;
`else
  assign hz.StallCnt = {CNT_W{1'b0}};
  assign hz.FlushCnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MUL_LAT=4, CNT_W=2) with an expected-value queue.
// Counter expectations follow HAZARD_PERF_EN when it is defined for the build.
module tb_hazard_unit_mc;
  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;
  exp_t sb[$];

  hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  hazard_unit_mc #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, MulBusy, MulDoneE}
  function automatic logic [11:0] ev(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic mb, input logic md);
    return {sf, sd, se, fd, fe, fm, fa, fb, mb, md};
  endfunction

  function automatic logic [11:0] obs();
    return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
            hz.ForwardAE, hz.ForwardBE, hz.MulBusy, hz.MulDoneE};
  endfunction

  // Inputs are already driven for this cycle; check mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input logic [11:0] e);
    exp_t x;
    logic [11:0] o;
    sb.push_back('{tag, e});
    @(negedge clk);
    x = sb.pop_front();
    o = obs();
    checks++;
    assert (o === x.val) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", x.tag, o, x.val);
    end
    $display("step %-14s outputs=%b", x.tag, o);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
    $display("count %-13s value=%0d", tag, o);
  endtask

  task automatic clear_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0; hz.MulStartE = 1'b0;
  endtask

  localparam logic [11:0] IDLE_V = 12'b0;
  localparam logic [11:0] BUSY_V = 12'b111001000010;
  localparam logic [11:0] DONE_V = 12'b000000000001;

  initial begin
    logic [CNT_W-1:0] expCnt;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    step("reset", IDLE_V);
    rst = 1'b0;

    // Forwarding on A, priority M over W, x0 never forwarded
    hz.RdM = 5; hz.RegWriteM = 1'b1; hz.RdW = 5; hz.RegWriteW = 1'b1; hz.Rs1E = 5;
    step("fwdA_M", ev(0,0,0,0,0,0,2'b10,2'b00,0,0));
    hz.RdM = 0;
    step("fwdA_W", ev(0,0,0,0,0,0,2'b01,2'b00,0,0));
    hz.Rs1E = 0; hz.RdW = 0;
    step("fwdA_zero", ev(0,0,0,0,0,0,2'b00,2'b00,0,0));
    // Forwarding on B
    hz.Rs2E = 9; hz.RdM = 6; hz.RdW = 9;
    step("fwdB_W", ev(0,0,0,0,0,0,2'b00,2'b01,0,0));
    hz.RdM = 9;
    step("fwdB_M", ev(0,0,0,0,0,0,2'b00,2'b10,0,0));
    hz.RegWriteM = 1'b0;
    step("fwdB_noWrM", ev(0,0,0,0,0,0,2'b00,2'b01,0,0));
    clear_inputs();

    // Load-use for exactly one cycle
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
    step("lw_stall", ev(1,1,0,0,1,0,2'b00,2'b00,0,0));
    clear_inputs();
    step("lw_gone", IDLE_V);
    hz.ResultSrcE = 2'b01; hz.RdE = 0; hz.Rs2D = 0;
    step("lw_x0", IDLE_V);
    clear_inputs();

    // Taken branch
    hz.PCSrcE = 1'b1;
    step("branch", ev(0,0,0,1,1,0,2'b00,2'b00,0,0));
    hz.PCSrcE = 1'b0;
    step("branch_gone", IDLE_V);

    // Multi-cycle op with start held, then a back-to-back op
    hz.MulStartE = 1'b1;
    step("mul_c0", IDLE_V);
    step("mul_busy1", BUSY_V);
    step("mul_busy2", BUSY_V);
    step("mul_done", DONE_V);
    step("mul2_c0", IDLE_V);
    step("mul2_busy1", BUSY_V);
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs1D = 7;
    step("mul2_busy_lw", BUSY_V);
    hz.ResultSrcE = 2'b00; hz.RdE = 0; hz.Rs1D = 0;
    step("mul2_done", DONE_V);
    hz.MulStartE = 1'b0;
    step("mul_idle", IDLE_V);

    // Branch and start together: branch wins, no op starts
    hz.PCSrcE = 1'b1; hz.MulStartE = 1'b1;
    step("br_vs_mul", ev(0,0,0,1,1,0,2'b00,2'b00,0,0));
    clear_inputs();
    step("br_vs_mul_nxt", IDLE_V);

    // Reset during the second busy cycle aborts without a DONE cycle
    hz.MulStartE = 1'b1;
    step("rmul_c0", IDLE_V);
    hz.MulStartE = 1'b0;
    step("rmul_busy1", BUSY_V);
    rst = 1'b1;
    step("rmul_busy2", BUSY_V);
    rst = 1'b0;
    step("rmul_abort", IDLE_V);
    step("rmul_nodone", IDLE_V);

    // Performance counters: five load-use cycles after a reset
    rst = 1'b1;
    step("perf_rst", IDLE_V);
    rst = 1'b0;
    check_cnt("stall_cnt_rst", hz.StallCnt, '0);
    check_cnt("flush_cnt_rst", hz.FlushCnt, '0);
    hz.ResultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3;
    for (int i = 0; i < 5; i++) step("perf_lw", ev(1,1,0,0,1,0,2'b00,2'b00,0,0));
    clear_inputs();
`ifdef HAZARD_PERF_EN
    expCnt = 2'd3;
`else
    expCnt = 2'd0;
`endif
    check_cnt("stall_cnt", hz.StallCnt, expCnt);
    check_cnt("flush_cnt", hz.FlushCnt, expCnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
